// File: rtl/dmi_tl_pkg.sv
// Shared encodings for the DMI-to-TileLink-UL bridge: DMI ops/responses,
// TileLink opcodes and the bridge state enum.
package dmi_tl_pkg;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_OK     = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;

    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_A_REQ  = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_RESP   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/dmi_to_tl_bridge_if.sv
// Bus bundle of the bridge: DMI request/response plus TileLink A/D channels.
// Every channel uses valid/ready: a beat transfers on the rising clock edge
// where both are high; valid never depends on ready and the bits are held
// stable while valid is high and ready is low.
interface dmi_to_tl_bridge_if;
    logic        io_dmi_req_valid;
    logic        io_dmi_req_ready;
    logic [6:0]  io_dmi_req_bits_addr;
    logic [31:0] io_dmi_req_bits_data;
    logic [1:0]  io_dmi_req_bits_op;
    logic        io_dmi_resp_valid;
    logic        io_dmi_resp_ready;
    logic [31:0] io_dmi_resp_bits_data;
    logic [1:0]  io_dmi_resp_bits_resp;
    logic        auto_out_a_ready;
    logic        auto_out_a_valid;
    logic [2:0]  auto_out_a_bits_opcode;
    logic [8:0]  auto_out_a_bits_address;
    logic [31:0] auto_out_a_bits_data;
    logic        auto_out_d_ready;
    logic        auto_out_d_valid;
    logic [2:0]  auto_out_d_bits_opcode;
    logic [1:0]  auto_out_d_bits_param;
    logic [1:0]  auto_out_d_bits_size;
    logic        auto_out_d_bits_source;
    logic        auto_out_d_bits_sink;
    logic        auto_out_d_bits_denied;
    logic [31:0] auto_out_d_bits_data;
    logic        auto_out_d_bits_corrupt;

    // Bridge side.
    modport slave (
        input  io_dmi_req_valid, io_dmi_req_bits_addr, io_dmi_req_bits_data,
               io_dmi_req_bits_op, io_dmi_resp_ready, auto_out_a_ready,
               auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
               auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink,
               auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt,
        output io_dmi_req_ready, io_dmi_resp_valid, io_dmi_resp_bits_data,
               io_dmi_resp_bits_resp, auto_out_a_valid, auto_out_a_bits_opcode,
               auto_out_a_bits_address, auto_out_a_bits_data, auto_out_d_ready
    );

    // Environment side: DMI host plus downstream TileLink slave.
    modport master (
        output io_dmi_req_valid, io_dmi_req_bits_addr, io_dmi_req_bits_data,
               io_dmi_req_bits_op, io_dmi_resp_ready, auto_out_a_ready,
               auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
               auto_out_d_bits_size, auto_out_d_bits_source, auto_out_d_bits_sink,
               auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt,
        input  io_dmi_req_ready, io_dmi_resp_valid, io_dmi_resp_bits_data,
               io_dmi_resp_bits_resp, auto_out_a_valid, auto_out_a_bits_opcode,
               auto_out_a_bits_address, auto_out_a_bits_data, auto_out_d_ready
    );
endinterface

// File: rtl/dmi_tl_timeout.sv
// Saturating D-wait counter; o_expired flags the last allowed wait cycle.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module dmi_tl_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == CW'(LIMIT));
endmodule

// File: rtl/dmi_to_tl_bridge.sv
// DMI to single-beat TileLink-UL bridge with one outstanding request,
// a D-channel response timeout and draining of late replies.
module dmi_to_tl_bridge
    import dmi_tl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    dmi_to_tl_bridge_if.slave    bus,
    output state_t               o_dbg_state
);
    state_t      r_state, w_next;
    logic        r_drain_pend;
    logic [2:0]  r_a_opcode;
    logic [8:0]  r_a_addr;
    logic [31:0] r_a_data;
    logic [31:0] r_resp_data;
    logic [1:0]  r_resp_code;

    logic        w_req_fire, w_a_fire, w_d_fire, w_resp_fire, w_d_ready, w_expired;
    logic        w_load_a, w_load_resp, w_drain_set, w_drain_clr;
    logic [31:0] w_resp_data_n;
    logic [1:0]  w_resp_code_n;
    logic        w_unused_d;

    assign w_unused_d = ^{bus.auto_out_d_bits_param, bus.auto_out_d_bits_size,
                          bus.auto_out_d_bits_source, bus.auto_out_d_bits_sink};

    assign w_d_ready   = (r_state == ST_D_WAIT) || (r_state == ST_DRAIN) ||
                         ((r_state == ST_RESP) && r_drain_pend);
    assign w_req_fire  = bus.io_dmi_req_valid && (r_state == ST_IDLE);
    assign w_a_fire    = bus.auto_out_a_ready && (r_state == ST_A_REQ);
    assign w_d_fire    = bus.auto_out_d_valid && w_d_ready;
    assign w_resp_fire = bus.io_dmi_resp_ready && (r_state == ST_RESP);

    dmi_tl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_a_fire),
        .i_en      (r_state == ST_D_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_load_a      = 1'b0;
        w_load_resp   = 1'b0;
        w_drain_set   = 1'b0;
        w_drain_clr   = 1'b0;
        w_resp_data_n = '0;
        w_resp_code_n = DMI_RESP_OK;
        case (r_state)
            ST_IDLE: begin
                if (w_req_fire) begin
                    if ((bus.io_dmi_req_bits_op == DMI_OP_READ) ||
                        (bus.io_dmi_req_bits_op == DMI_OP_WRITE)) begin
                        w_next   = ST_A_REQ;
                        w_load_a = 1'b1;
                    end else begin
                        w_next      = ST_RESP;
                        w_load_resp = 1'b1;
                    end
                end
            end
            ST_A_REQ: begin
                if (w_a_fire) w_next = ST_D_WAIT;
            end
            ST_D_WAIT: begin
                // A reply in the expiry cycle still wins over the timeout.
                if (w_d_fire) begin
                    w_next      = ST_RESP;
                    w_load_resp = 1'b1;
                    if (bus.auto_out_d_bits_denied || bus.auto_out_d_bits_corrupt)
                        w_resp_code_n = DMI_RESP_FAILED;
                    if (bus.auto_out_d_bits_opcode == TL_ACCESS_ACK_DATA)
                        w_resp_data_n = bus.auto_out_d_bits_data;
                end else if (w_expired) begin
                    w_next        = ST_RESP;
                    w_load_resp   = 1'b1;
                    w_resp_code_n = DMI_RESP_FAILED;
                    w_drain_set   = 1'b1;
                end
            end
            ST_RESP: begin
                if (w_d_fire) w_drain_clr = 1'b1;
                if (w_resp_fire)
                    w_next = (r_drain_pend && !w_d_fire) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (w_d_fire) begin
                    w_next      = ST_IDLE;
                    w_drain_clr = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drain_pend <= 1'b0;
            r_a_opcode   <= '0;
            r_a_addr     <= '0;
            r_a_data     <= '0;
            r_resp_data  <= '0;
            r_resp_code  <= '0;
        end else begin
            if (w_drain_set)      r_drain_pend <= 1'b1;
            else if (w_drain_clr) r_drain_pend <= 1'b0;
            if (w_load_a) begin
                r_a_opcode <= (bus.io_dmi_req_bits_op == DMI_OP_READ) ? TL_GET : TL_PUT_FULL;
                r_a_addr   <= {bus.io_dmi_req_bits_addr, 2'b00};
                r_a_data   <= (bus.io_dmi_req_bits_op == DMI_OP_WRITE) ?
                              bus.io_dmi_req_bits_data : 32'd0;
            end
            if (w_load_resp) begin
                r_resp_data <= w_resp_data_n;
                r_resp_code <= w_resp_code_n;
            end
        end
    end

    assign bus.io_dmi_req_ready        = (r_state == ST_IDLE);
    assign bus.auto_out_a_valid        = (r_state == ST_A_REQ);
    assign bus.auto_out_a_bits_opcode  = r_a_opcode;
    assign bus.auto_out_a_bits_address = r_a_addr;
    assign bus.auto_out_a_bits_data    = r_a_data;
    assign bus.auto_out_d_ready        = w_d_ready;
    assign bus.io_dmi_resp_valid       = (r_state == ST_RESP);
    assign bus.io_dmi_resp_bits_data   = r_resp_data;
    assign bus.io_dmi_resp_bits_resp   = r_resp_code;
    assign o_dbg_state                 = r_state;
endmodule

// File: tb/tb_dmi_to_tl_bridge.sv
// Directed bench for dmi_to_tl_bridge with TIMEOUT_CYCLES = 8.
module tb_dmi_to_tl_bridge;
    import dmi_tl_pkg::*;

    logic   clock = 1'b0;
    logic   reset = 1'b0;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_errors = 0;
    logic [33:0] exp_q[$];

    dmi_to_tl_bridge_if bus();

    dmi_to_tl_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.io_dmi_req_ready, 1);
        check({tag, "_a_valid"}, bus.auto_out_a_valid, 0);
        check({tag, "_a_bits"}, {bus.auto_out_a_bits_opcode, bus.auto_out_a_bits_address,
                                 bus.auto_out_a_bits_data}, 0);
        check({tag, "_d_ready"}, bus.auto_out_d_ready, 0);
        check({tag, "_resp_valid"}, bus.io_dmi_resp_valid, 0);
        check({tag, "_resp_bits"}, {bus.io_dmi_resp_bits_resp, bus.io_dmi_resp_bits_data}, 0);
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [31:0] data,
                           input logic den, input logic cor);
        bus.auto_out_d_valid        = 1'b1;
        bus.auto_out_d_bits_opcode  = op;
        bus.auto_out_d_bits_data    = data;
        bus.auto_out_d_bits_denied  = den;
        bus.auto_out_d_bits_corrupt = cor;
    endtask

    task automatic clear_d();
        bus.auto_out_d_valid        = 1'b0;
        bus.auto_out_d_bits_opcode  = 3'd0;
        bus.auto_out_d_bits_data    = 32'd0;
        bus.auto_out_d_bits_denied  = 1'b0;
        bus.auto_out_d_bits_corrupt = 1'b0;
    endtask

    // Issues a request, returns to IDLE after the response fires.
    task automatic issue_req(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata);
        bus.io_dmi_req_valid     = 1'b1;
        bus.io_dmi_req_bits_op   = op;
        bus.io_dmi_req_bits_addr = addr;
        bus.io_dmi_req_bits_data = wdata;
        check("req_ready_idle", bus.io_dmi_req_ready, 1);
        tick();
        bus.io_dmi_req_valid     = 1'b0;
        bus.io_dmi_req_bits_op   = 2'd0;
        bus.io_dmi_req_bits_addr = 7'd0;
        bus.io_dmi_req_bits_data = 32'd0;
    endtask

    task automatic run_txn(
        input logic [1:0]  op, input logic [6:0] addr, input logic [31:0] wdata,
        input int a_stall, input int d_delay, input int r_stall,
        input logic [2:0]  d_op, input logic [31:0] d_data, input logic den, input logic cor,
        input logic [2:0]  exp_aop, input logic [8:0] exp_aaddr, input logic [31:0] exp_adata,
        input logic [1:0]  exp_resp, input logic [31:0] exp_rdata
    );
        logic [33:0] e;
        exp_q.push_back({exp_resp, exp_rdata});
        issue_req(op, addr, wdata);
        if ((op == DMI_OP_READ) || (op == DMI_OP_WRITE)) begin
            for (int i = 0; i <= a_stall; i++) begin
                bus.auto_out_a_ready = (i == a_stall);
                check("a_valid", bus.auto_out_a_valid, 1);
                check("a_opcode", bus.auto_out_a_bits_opcode, exp_aop);
                check("a_address", bus.auto_out_a_bits_address, exp_aaddr);
                check("a_data", bus.auto_out_a_bits_data, exp_adata);
                check("req_ready_busy", bus.io_dmi_req_ready, 0);
                tick();
            end
            bus.auto_out_a_ready = 1'b0;
            check("a_valid_after_fire", bus.auto_out_a_valid, 0);
            for (int i = 0; i < d_delay; i++) begin
                check("d_ready_wait", bus.auto_out_d_ready, 1);
                check("resp_valid_wait", bus.io_dmi_resp_valid, 0);
                tick();
            end
            drive_d(d_op, d_data, den, cor);
            check("d_ready_accept", bus.auto_out_d_ready, 1);
            tick();
            clear_d();
        end else begin
            check("a_valid_nop", bus.auto_out_a_valid, 0);
        end
        for (int i = 0; i <= r_stall; i++) begin
            bus.io_dmi_resp_ready = (i == r_stall);
            e = exp_q[0];
            check("resp_valid", bus.io_dmi_resp_valid, 1);
            check("resp_data", bus.io_dmi_resp_bits_data, e[31:0]);
            check("resp_code", bus.io_dmi_resp_bits_resp, e[33:32]);
            check("req_ready_resp", bus.io_dmi_req_ready, 0);
            tick();
        end
        bus.io_dmi_resp_ready = 1'b0;
        void'(exp_q.pop_front());
        check("resp_valid_done", bus.io_dmi_resp_valid, 0);
        check("req_ready_done", bus.io_dmi_req_ready, 1);
        check("d_ready_done", bus.auto_out_d_ready, 0);
        check("state_done", dbg_state, ST_IDLE);
    endtask

    // Read whose reply never comes; returns in RESP with the failed response.
    task automatic read_until_timeout(input logic [6:0] addr);
        int waited;
        issue_req(DMI_OP_READ, addr, 32'd0);
        bus.auto_out_a_ready = 1'b1;
        tick();
        bus.auto_out_a_ready = 1'b0;
        waited = 0;
        while (!bus.io_dmi_resp_valid && waited < 50) begin
            tick();
            waited++;
        end
        check("timeout_cycles", waited, 8);
        check("timeout_resp", bus.io_dmi_resp_bits_resp, DMI_RESP_FAILED);
        check("timeout_data", bus.io_dmi_resp_bits_data, 0);
        check("timeout_d_ready", bus.auto_out_d_ready, 1);
    endtask

    initial begin
        bus.io_dmi_req_valid     = 1'b0;
        bus.io_dmi_req_bits_op   = 2'd0;
        bus.io_dmi_req_bits_addr = 7'd0;
        bus.io_dmi_req_bits_data = 32'd0;
        bus.io_dmi_resp_ready    = 1'b0;
        bus.auto_out_a_ready     = 1'b0;
        bus.auto_out_d_bits_param  = 2'd0;
        bus.auto_out_d_bits_size   = 2'd2;
        bus.auto_out_d_bits_source = 1'b0;
        bus.auto_out_d_bits_sink   = 1'b0;
        clear_d();
        #12;
        check_reset_outputs("reset");
        check("reset_state", dbg_state, ST_IDLE);
        reset = 1'b1;
        tick();

        // Read, write, denied, corrupt
        run_txn(DMI_OP_READ, 7'h11, 32'd0, 0, 0, 0, TL_ACCESS_ACK_DATA, 32'hDEADBEEF, 0, 0,
                TL_GET, 9'h044, 32'd0, DMI_RESP_OK, 32'hDEADBEEF);
        run_txn(DMI_OP_WRITE, 7'h10, 32'h1, 0, 0, 0, TL_ACCESS_ACK, 32'h55, 0, 0,
                TL_PUT_FULL, 9'h040, 32'h1, DMI_RESP_OK, 32'd0);
        run_txn(DMI_OP_READ, 7'h05, 32'd0, 0, 1, 0, TL_ACCESS_ACK_DATA, 32'h12345678, 1, 0,
                TL_GET, 9'h014, 32'd0, DMI_RESP_FAILED, 32'h12345678);
        run_txn(DMI_OP_READ, 7'h7F, 32'd0, 0, 0, 0, TL_ACCESS_ACK_DATA, 32'hCAFEF00D, 0, 1,
                TL_GET, 9'h1FC, 32'd0, DMI_RESP_FAILED, 32'hCAFEF00D);

        // Backpressure on A and on the response
        run_txn(DMI_OP_WRITE, 7'h22, 32'hA5A55A5A, 5, 2, 3, TL_ACCESS_ACK, 32'd0, 0, 0,
                TL_PUT_FULL, 9'h088, 32'hA5A55A5A, DMI_RESP_OK, 32'd0);

        // NOP and reserved op: no TL traffic
        run_txn(DMI_OP_NOP, 7'h33, 32'h77, 0, 0, 0, 3'd0, 32'd0, 0, 0,
                3'd0, 9'd0, 32'd0, DMI_RESP_OK, 32'd0);
        run_txn(2'd3, 7'h44, 32'h88, 0, 0, 0, 3'd0, 32'd0, 0, 0,
                3'd0, 9'd0, 32'd0, DMI_RESP_OK, 32'd0);

        // Reply arriving in the expiry cycle wins
        run_txn(DMI_OP_READ, 7'h01, 32'd0, 0, 7, 0, TL_ACCESS_ACK_DATA, 32'h0BADF00D, 0, 0,
                TL_GET, 9'h004, 32'd0, DMI_RESP_OK, 32'h0BADF00D);

        // Unexpected D in IDLE is ignored
        drive_d(TL_ACCESS_ACK_DATA, 32'h99, 0, 0);
        check("unexp_d_ready", bus.auto_out_d_ready, 0);
        tick();
        check("unexp_state", dbg_state, ST_IDLE);
        check("unexp_resp_valid", bus.io_dmi_resp_valid, 0);
        clear_d();

        // Timeout, then drain the late reply in DRAIN
        read_until_timeout(7'h02);
        bus.io_dmi_resp_ready = 1'b1;
        tick();
        bus.io_dmi_resp_ready = 1'b0;
        check("drain_state", dbg_state, ST_DRAIN);
        check("drain_d_ready", bus.auto_out_d_ready, 1);
        check("drain_req_ready", bus.io_dmi_req_ready, 0);
        tick();
        tick();
        drive_d(TL_ACCESS_ACK_DATA, 32'hAAAA5555, 0, 0);
        tick();
        clear_d();
        check("drain_done_state", dbg_state, ST_IDLE);
        check("drain_done_d_ready", bus.auto_out_d_ready, 0);
        check("drain_done_resp_valid", bus.io_dmi_resp_valid, 0);
        run_txn(DMI_OP_WRITE, 7'h03, 32'h0000BEEF, 0, 0, 0, TL_ACCESS_ACK, 32'd0, 0, 0,
                TL_PUT_FULL, 9'h00C, 32'h0000BEEF, DMI_RESP_OK, 32'd0);

        // Timeout, late reply consumed while the response is still pending
        read_until_timeout(7'h06);
        drive_d(TL_ACCESS_ACK_DATA, 32'h5A5A5A5A, 0, 0);
        tick();
        clear_d();
        check("late_in_resp_d_ready", bus.auto_out_d_ready, 0);
        check("late_in_resp_data", bus.io_dmi_resp_bits_data, 0);
        bus.io_dmi_resp_ready = 1'b1;
        tick();
        bus.io_dmi_resp_ready = 1'b0;
        check("late_in_resp_state", dbg_state, ST_IDLE);
        run_txn(DMI_OP_READ, 7'h08, 32'd0, 0, 0, 0, TL_ACCESS_ACK_DATA, 32'h13572468, 0, 0,
                TL_GET, 9'h020, 32'd0, DMI_RESP_OK, 32'h13572468);

        // Reset asserted in D_WAIT
        issue_req(DMI_OP_READ, 7'h15, 32'd0);
        bus.auto_out_a_ready = 1'b1;
        tick();
        bus.auto_out_a_ready = 1'b0;
        check("pre_reset_state", dbg_state, ST_D_WAIT);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_state", dbg_state, ST_IDLE);
        tick();
        reset = 1'b1;
        tick();
        run_txn(DMI_OP_NOP, 7'h00, 32'd0, 0, 0, 0, 3'd0, 32'd0, 0, 0,
                3'd0, 9'd0, 32'd0, DMI_RESP_OK, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmi_to_tl_bridge.md
# dmi_to_tl_bridge

Converts Debug Module Interface (DMI) requests into single-beat TileLink-UL transactions, and converts the matching D-channel replies back into DMI responses. Sits directly upstream of the debug-bus bypass stage: its A-channel output drives that stage's `auto_node_in_in_a_*` port, and it consumes that stage's `auto_node_in_in_d_*` output. It allows one outstanding request. A response timeout guarantees the DMI side always gets an answer; a reply that arrives after the timeout is drained and discarded.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: number of D-wait cycles before a failed response is synthesised. 0 disables the timeout.

Ports:
- `clock`  in  1  single clock for the whole block
- `reset`  in  1  asynchronous, active-low reset
- `io_dmi_req_valid` / `io_dmi_req_ready`  in/out  1/1  DMI request handshake
- `io_dmi_req_bits_addr`  in  7  DMI word address
- `io_dmi_req_bits_data`  in  32  write data
- `io_dmi_req_bits_op`  in  2  0 = NOP, 1 = read, 2 = write, 3 = reserved (treated as NOP)
- `io_dmi_resp_valid` / `io_dmi_resp_ready`  out/in  1/1  DMI response handshake
- `io_dmi_resp_bits_data`  out  32  read data; 0 for writes and NOPs
- `io_dmi_resp_bits_resp`  out  2  0 = success, 2 = failed
- `auto_out_a_ready`  in  1; `auto_out_a_valid`  out  1
- `auto_out_a_bits_opcode`  out  3  4 = Get, 0 = PutFullData
- `auto_out_a_bits_address`  out  9  {addr, 2'b00}
- `auto_out_a_bits_data`  out  32  write data; 0 for Get
- `auto_out_d_ready`  out  1; `auto_out_d_valid`  in  1
- `auto_out_d_bits_opcode`  in  3; `auto_out_d_bits_param`  in  2; `auto_out_d_bits_size`  in  2; `auto_out_d_bits_source`  in  1; `auto_out_d_bits_sink`  in  1; `auto_out_d_bits_denied`  in  1; `auto_out_d_bits_data`  in  32; `auto_out_d_bits_corrupt`  in  1

## Operation
States and transitions:
- IDLE → A_REQ on request fire with op 1 or 2.
- IDLE → RESP on request fire with op 0 or 3. No TL traffic; resp = 0, data = 0.
- A_REQ → D_WAIT on A fire.
- D_WAIT → RESP on D fire. resp = 2 if `denied` or `corrupt`, else 0. data = D data if opcode is AccessAckData (1), else 0.
- D_WAIT → RESP on timeout (counter == TIMEOUT_CYCLES − 1 with no D). resp = 2, data = 0, `drain_pend` set.
- RESP → IDLE on response fire; → DRAIN instead if `drain_pend` is set and the late D has not yet been consumed.
- DRAIN → IDLE on D fire. The D beat is discarded.

Handshake and output rules:
- `io_dmi_req_ready` = (state == IDLE).
- `auto_out_a_valid` = (state == A_REQ). A bits are held stable until A fires. A_REQ never times out, so valid is never retracted.
- `auto_out_d_ready` = D_WAIT or DRAIN, or RESP with `drain_pend` set; a late D accepted in RESP clears `drain_pend`.
- `io_dmi_resp_valid` = (state == RESP). Response bits are registered and held until it fires.
- Unexpected D (D valid in IDLE or A_REQ) is not accepted (ready = 0) and has no effect.
- The timeout counter clears on entry to D_WAIT, increments each D_WAIT cycle, and saturates.

## Timing
- Reset (async assert, sync deassert upstream): state = IDLE, `drain_pend` = 0, counter = 0.
- All outputs at reset: `io_dmi_req_ready` = 1, every valid = 0, all bits = 0, `auto_out_d_ready` = 0.
- Read or write latency: request fire at cycle 0, A valid at cycle 1. With `a_ready` = 1, D can be accepted from cycle 2 at the earliest and the response is valid at cycle 3.
- NOP latency: response valid at cycle 1.
- Reset asserted mid-transaction abandons it immediately. The downstream must also be reset; the bridge keeps no record of it.
- D fire and timeout in the same cycle: D wins, and the response carries the real data and status.

## Structure
- Package `dmi_tl_pkg` holds:
  - DMI op and resp encodings
  - TL opcodes Get, PutFullData, AccessAck, AccessAckData
  - the state enum
- Sub-module `dmi_tl_timeout`: clear, enable, saturating counter, and `expired` output, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Read: op 1, addr 0x11; D returns AccessAckData, data 0xDEADBEEF → A is Get at 0x044; response data 0xDEADBEEF, resp 0.
- Write: op 2, addr 0x10, data 0x1; D returns AccessAck → A is PutFullData at 0x040, data 0x1; response resp 0, data 0.
- Denied: read with D `denied` = 1 → resp 2. Separately, `corrupt` = 1 → resp 2.
- Backpressure: hold `a_ready` = 0 for 5 cycles, then `resp_ready` = 0 for 3 cycles → A bits and response bits stable throughout; `req_ready` = 0 until the response fires.
- Timeout: `TIMEOUT_CYCLES` = 8, no D → resp 2 after 8 D_WAIT cycles. A D injected 4 cycles later is drained, and the next request proceeds normally.
- NOP, and reset asserted in D_WAIT: NOP gives a response at cycle 1 with no A valid. Reset returns all outputs to their reset values within the same cycle.
